// File: rtl/hit_sel_sched.sv
// Hit-driven round-robin grant scheduler.
// A requester whose hit rises while the shared resource is not pending is latched into a
// request mask. Requesters are granted one at a time in round-robin order. Each grant waits
// for pending to go high, then issues a one-cycle one-hot sel pulse to the owner.
// Optional feature macro: HIT_SEL_SCHED_TIMEOUT_EN adds a wait timeout with a timeout_err pulse.
module hit_sel_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned TMO  = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         hit,
   input  logic                    pending,
   output logic [NREQ-1:0]         sel,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int unsigned IdW = $clog2(NREQ);

   typedef enum logic [1:0] {StIdle, StWaitPend, StSel} state_e;

   // Reject configurations outside the supported range at elaboration
   if (NREQ < 2 || NREQ > 16 || TMO < 1 || TMO > 255) begin : g_bad_cfg
      $error("hit_sel_sched: NREQ or TMO out of range");
   end

   state_e             state_q, state_d;
   logic [NREQ-1:0]    prev_q;
   logic [NREQ-1:0]    mask_q, mask_d;
   logic [IdW-1:0]     grant_q, grant_d;
   logic [IdW-1:0]     last_q, last_d;
   logic [NREQ-1:0]    term, rise, cand, win_oh;
   logic [IdW-1:0]     win;
   logic               found;

`ifdef HIT_SEL_SCHED_TIMEOUT_EN
   logic [7:0]         cnt_q, cnt_d;
   logic               tmo_q, tmo_d;
`endif

   // Edge-detect the qualified hit term against its registered copy
   always_comb begin
      term = hit & {NREQ{~pending}};
      rise = term & ~prev_q;
      cand = mask_q | rise;
   end

   // Round-robin pick among candidates, searching from last_owner+1
   always_comb begin
      win    = last_q;
      found  = 1'b0;
      win_oh = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!found && cand[IdW'((32'(last_q) + i) % NREQ)]) begin
            found = 1'b1;
            win   = IdW'((32'(last_q) + i) % NREQ);
         end
      end
      win_oh[win] = 1'b1;
   end

   // Next-state logic; rises are always folded into the mask so none are lost
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q | rise;
      grant_d = grant_q;
      last_d  = last_q;
`ifdef HIT_SEL_SCHED_TIMEOUT_EN
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = win;
               mask_d  = mask_d & ~win_oh;
               state_d = StWaitPend;
`ifdef HIT_SEL_SCHED_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         StWaitPend: begin
            if (pending) begin
               state_d = StSel;
            end else begin
`ifdef HIT_SEL_SCHED_TIMEOUT_EN
               cnt_d = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == 8'(TMO)) begin
                  // Owner gives up: back to idle without a sel pulse
                  state_d         = StIdle;
                  tmo_d           = 1'b1;
                  last_d          = grant_q;
                  mask_d[grant_q] = 1'b0;
               end
`endif
            end
         end
         StSel: begin
            state_d = StIdle;
            last_d  = grant_q;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; last_owner resets to NREQ-1 so the first search starts at 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         prev_q  <= '0;
         mask_q  <= '0;
         grant_q <= '0;
         last_q  <= IdW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         prev_q  <= term;
         mask_q  <= mask_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef HIT_SEL_SCHED_TIMEOUT_EN
   // Wait-cycle counter and registered timeout pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end
   assign timeout_err = tmo_q;
`else
   assign timeout_err = 1'b0;
`endif

   // Outputs decoded from state only, so reset clears them immediately
   always_comb begin
      sel = '0;
      if (state_q == StSel) sel[grant_q] = 1'b1;
      busy     = (state_q != StIdle);
      grant_id = grant_q;
   end

endmodule

// File: tb/tb_hit_sel_sched.sv
// Directed self-checking bench for hit_sel_sched (NREQ=4, TMO=15).
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_hit_sel_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] hit;
   logic       pending;
   logic [3:0] sel;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   hit_sel_sched #(
      .NREQ (4),
      .TMO  (15)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hit         (hit),
      .pending     (pending),
      .sel         (sel),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] e_sel, input logic e_busy,
                            input logic [1:0] e_gid);
      check_eq({tag, ".sel"}, 32'(sel), 32'(e_sel));
      check_eq({tag, ".busy"}, 32'(busy), 32'(e_busy));
      check_eq({tag, ".gid"}, 32'(grant_id), 32'(e_gid));
      check_eq({tag, ".tmo"}, 32'(timeout_err), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; hit = '0; pending = 1'b0;
      #1;
      check_out("rst_async", 4'b0000, 1'b0, 2'd0);
      tick();
      tick();
      check_out("rst_hold", 4'b0000, 1'b0, 2'd0);
      rst = 1'b0;
      tick();

      // Single requester 2: rise, three wait cycles, pending, sel pulse
      hit = 4'b0100;
      tick();
      check_out("r2_wait1", 4'b0000, 1'b1, 2'd2);
      tick();
      check_out("r2_wait2", 4'b0000, 1'b1, 2'd2);
      tick();
      check_out("r2_wait3", 4'b0000, 1'b1, 2'd2);
      pending = 1'b1; hit = 4'b0000;
      tick();
      check_out("r2_sel", 4'b0100, 1'b1, 2'd2);
      pending = 1'b0;
      tick();
      check_out("r2_idle", 4'b0000, 1'b0, 2'd2);

      // Hit rises while pending is high: no trigger until pending drops
      hit = 4'b0010; pending = 1'b1;
      tick();
      check_out("r1_blk1", 4'b0000, 1'b0, 2'd2);
      tick();
      check_out("r1_blk2", 4'b0000, 1'b0, 2'd2);
      pending = 1'b0;
      tick();
      check_out("r1_wait", 4'b0000, 1'b1, 2'd1);
      pending = 1'b1; hit = 4'b0000;
      tick();
      check_out("r1_sel", 4'b0010, 1'b1, 2'd1);
      pending = 1'b0;
      tick();
      check_out("r1_idle", 4'b0000, 1'b0, 2'd1);

      // Simultaneous rises on 0 and 3 after reset: 0 first, then 3
      do_reset();
      tick();
      hit = 4'b1001;
      tick();
      check_out("rr_w0", 4'b0000, 1'b1, 2'd0);
      hit = 4'b0000; pending = 1'b1;
      tick();
      check_out("rr_s0", 4'b0001, 1'b1, 2'd0);
      pending = 1'b0;
      tick();
      check_out("rr_idle", 4'b0000, 1'b0, 2'd0);
      tick();
      check_out("rr_w3", 4'b0000, 1'b1, 2'd3);
      pending = 1'b1;
      tick();
      check_out("rr_s3", 4'b1000, 1'b1, 2'd3);
      pending = 1'b0;
      tick();
      check_out("rr_done", 4'b0000, 1'b0, 2'd3);
      tick();
      check_out("rr_quiet", 4'b0000, 1'b0, 2'd3);

      // Reset mid-wait aborts the transaction
      do_reset();
      tick();
      hit = 4'b0010;
      tick();
      check_out("ab_wait", 4'b0000, 1'b1, 2'd1);
      #2 rst = 1'b1;
      #1;
      check_out("ab_async", 4'b0000, 1'b0, 2'd0);
      hit = 4'b0000;
      tick();
      rst = 1'b0;
      pending = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_out("ab_after", 4'b0000, 1'b0, 2'd0);
      end
      pending = 1'b0;

      // Hit already high across reset release counts as a rise
      rst = 1'b1; hit = 4'b0100;
      tick();
      rst = 1'b0;
      tick();
      check_out("pre_wait", 4'b0000, 1'b1, 2'd2);
      hit = 4'b0000; pending = 1'b1;
      tick();
      check_out("pre_sel", 4'b0100, 1'b1, 2'd2);
      pending = 1'b0;
      tick();
      check_out("pre_idle", 4'b0000, 1'b0, 2'd2);

      // Pending held low on a granted request
      do_reset();
      tick();
      hit = 4'b0010;
      tick();
      hit = 4'b0000;
`ifdef HIT_SEL_SCHED_TIMEOUT_EN
      // Cycle 1 of WAIT_PEND was entered on the last edge; 15 wait cycles then timeout
      for (int k = 1; k <= 15; k++) begin
         check_out("to_wait", 4'b0000, 1'b1, 2'd1);
         tick();
      end
      check_eq("to_pulse", 32'(timeout_err), 32'd1);
      check_eq("to_busy", 32'(busy), 32'd0);
      check_eq("to_sel", 32'(sel), 32'd0);
      tick();
      check_out("to_after", 4'b0000, 1'b0, 2'd1);
      pending = 1'b1;
      tick();
      check_out("to_nosel", 4'b0000, 1'b0, 2'd1);
      pending = 1'b0;
`else
      for (int k = 1; k <= 20; k++) begin
         check_out("nt_wait", 4'b0000, 1'b1, 2'd1);
         tick();
      end
      pending = 1'b1;
      tick();
      check_out("nt_sel", 4'b0010, 1'b1, 2'd1);
      pending = 1'b0;
      tick();
      check_out("nt_idle", 4'b0000, 1'b0, 2'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
